// File: rtl/mem_arbiter.sv
// mem_arbiter
// N-master arbiter in front of a single-ported memory. One transaction is in
// flight at a time; the winner's fields are registered onto the memory port,
// read data is captured after MEM_LAT cycles, and the winner gets a one-cycle
// acknowledge. Round-robin or fixed-priority arbitration. A per-master lock,
// with an idle timeout, supports atomic read-modify-write sequences.
//
// Ports
//   CLK, RESET          clock, synchronous active-high reset
//   M_REQ/M_WE/M_LOCK   per-master request, write enable, lock-after-this
//   M_ADDR/M_WDATA/M_BE flattened per-master fields, master i in slice i
//   M_ACK               one-cycle completion pulse to the granted master
//   M_RDATA             shared read data, valid with any M_ACK bit
//   S_EN                one-cycle memory strobe per transaction
//   S_WE/S_ADDR/S_WDATA/S_BE  registered copy of the winner's fields
//   S_RDATA             memory read data, valid MEM_LAT cycles after S_EN
//   GRANT_ID            index of the current or last granted master
//   BUSY                high in every state except IDLE
//
// state | meaning
// IDLE  | arbitrate among requests (or honour / time out a held lock)
// ISSUE | S_EN high for one cycle, latency counter loaded
// WAIT  | count down memory latency, capture read data on the last cycle
// ACK   | M_ACK pulse to the winner, lock state updated, REQ not sampled
module mem_arbiter #(
  parameter int N_MASTERS = 3,
  parameter int ADDR_W    = 13,
  parameter int DATA_W    = 32,
  parameter int MEM_LAT   = 1,
  parameter int PRIO_MODE = 0,
  parameter int LOCK_TMO  = 16,
  localparam int ID_W     = $clog2(N_MASTERS),
  localparam int BE_W     = DATA_W / 8
) (
  input  logic                          CLK,
  input  logic                          RESET,
  input  logic [N_MASTERS-1:0]          M_REQ,
  input  logic [N_MASTERS-1:0]          M_WE,
  input  logic [N_MASTERS-1:0]          M_LOCK,
  input  logic [N_MASTERS*ADDR_W-1:0]   M_ADDR,
  input  logic [N_MASTERS*DATA_W-1:0]   M_WDATA,
  input  logic [N_MASTERS*BE_W-1:0]     M_BE,
  output logic [N_MASTERS-1:0]          M_ACK,
  output logic [DATA_W-1:0]             M_RDATA,
  output logic                          S_EN,
  output logic                          S_WE,
  output logic [ADDR_W-1:0]             S_ADDR,
  output logic [DATA_W-1:0]             S_WDATA,
  output logic [BE_W-1:0]               S_BE,
  input  logic [DATA_W-1:0]             S_RDATA,
  output logic [ID_W-1:0]               GRANT_ID,
  output logic                          BUSY
);

  localparam int CNT_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_ACK
  } state_t;

  state_t               state_q, state_d;
  logic [ID_W-1:0]      last_q, last_d;
  logic [ID_W-1:0]      grant_id_q, grant_id_d;
  logic                 lock_valid_q, lock_valid_d;
  logic [ID_W-1:0]      lock_owner_q, lock_owner_d;
  logic                 lock_req_q, lock_req_d;
  logic [7:0]           tmo_q, tmo_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [N_MASTERS-1:0] m_ack_q, m_ack_d;
  logic [DATA_W-1:0]    m_rdata_q, m_rdata_d;
  logic                 s_en_q, s_en_d;
  logic                 s_we_q, s_we_d;
  logic [ADDR_W-1:0]    s_addr_q, s_addr_d;
  logic [DATA_W-1:0]    s_wdata_q, s_wdata_d;
  logic [BE_W-1:0]      s_be_q, s_be_d;
  logic                 busy_q, busy_d;

  logic [ADDR_W-1:0]    addr_arr  [N_MASTERS];
  logic [DATA_W-1:0]    wdata_arr [N_MASTERS];
  logic [BE_W-1:0]      be_arr    [N_MASTERS];

  logic                 win_valid;
  logic [ID_W-1:0]      win_id;
  logic [ID_W-1:0]      cand;
  logic                 do_grant;
  logic [ID_W-1:0]      sel_id;

  for (genvar g = 0; g < N_MASTERS; g++) begin : g_split
    assign addr_arr[g]  = M_ADDR[g*ADDR_W +: ADDR_W];
    assign wdata_arr[g] = M_WDATA[g*DATA_W +: DATA_W];
    assign be_arr[g]    = M_BE[g*BE_W +: BE_W];
  end

  // Arbitration. Loops run from lowest to highest priority so the last hit
  // is the winner. Round-robin offset N_MASTERS is LAST itself, i.e. the
  // most recently served master is considered last.
  always_comb begin
    win_valid = 1'b0;
    win_id    = '0;
    cand      = '0;
    if (PRIO_MODE == 1) begin
      for (int i = N_MASTERS - 1; i >= 0; i--) begin
        cand = ID_W'(i);
        if (M_REQ[cand]) begin
          win_valid = 1'b1;
          win_id    = cand;
        end
      end
    end else begin
      for (int k = N_MASTERS; k >= 1; k--) begin
        cand = ID_W'((int'(last_q) + k) % N_MASTERS);
        if (M_REQ[cand]) begin
          win_valid = 1'b1;
          win_id    = cand;
        end
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    last_d       = last_q;
    grant_id_d   = grant_id_q;
    lock_valid_d = lock_valid_q;
    lock_owner_d = lock_owner_q;
    lock_req_d   = lock_req_q;
    tmo_d        = tmo_q;
    cnt_d        = cnt_q;
    m_ack_d      = '0;
    m_rdata_d    = m_rdata_q;
    s_en_d       = 1'b0;
    s_we_d       = s_we_q;
    s_addr_d     = s_addr_q;
    s_wdata_d    = s_wdata_q;
    s_be_d       = s_be_q;
    do_grant     = 1'b0;
    sel_id       = win_id;

    case (state_q)
      ST_IDLE: begin
        if (lock_valid_q) begin
          // A held lock either hands the port straight back to its owner or
          // blocks everyone else until the idle timeout expires.
          if (M_REQ[lock_owner_q]) begin
            do_grant = 1'b1;
            sel_id   = lock_owner_q;
          end else begin
            tmo_d = tmo_q + 8'd1;
            if (tmo_d >= 8'(LOCK_TMO)) begin
              lock_valid_d = 1'b0;
            end
          end
        end else if (win_valid) begin
          do_grant = 1'b1;
        end

        if (do_grant) begin
          grant_id_d = sel_id;
          last_d     = sel_id;
          lock_req_d = M_LOCK[sel_id];
          s_we_d     = M_WE[sel_id];
          s_addr_d   = addr_arr[sel_id];
          s_wdata_d  = wdata_arr[sel_id];
          s_be_d     = be_arr[sel_id];
          s_en_d     = 1'b1;
          state_d    = ST_ISSUE;
        end
      end

      ST_ISSUE: begin
        cnt_d   = CNT_W'(MEM_LAT);
        state_d = ST_WAIT;
      end

      ST_WAIT: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) begin
          if (!s_we_q) begin
            m_rdata_d = S_RDATA;
          end
          m_ack_d[grant_id_q] = 1'b1;
          state_d             = ST_ACK;
        end
      end

      ST_ACK: begin
        if (lock_req_q) begin
          lock_valid_d = 1'b1;
          lock_owner_d = grant_id_q;
          tmo_d        = 8'd0;
        end else if (lock_valid_q && (lock_owner_q == grant_id_q)) begin
          lock_valid_d = 1'b0;
        end
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q      <= ST_IDLE;
      last_q       <= ID_W'(N_MASTERS - 1);
      grant_id_q   <= '0;
      lock_valid_q <= 1'b0;
      lock_owner_q <= '0;
      lock_req_q   <= 1'b0;
      tmo_q        <= '0;
      cnt_q        <= '0;
      m_ack_q      <= '0;
      m_rdata_q    <= '0;
      s_en_q       <= 1'b0;
      s_we_q       <= 1'b0;
      s_addr_q     <= '0;
      s_wdata_q    <= '0;
      s_be_q       <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_q       <= last_d;
      grant_id_q   <= grant_id_d;
      lock_valid_q <= lock_valid_d;
      lock_owner_q <= lock_owner_d;
      lock_req_q   <= lock_req_d;
      tmo_q        <= tmo_d;
      cnt_q        <= cnt_d;
      m_ack_q      <= m_ack_d;
      m_rdata_q    <= m_rdata_d;
      s_en_q       <= s_en_d;
      s_we_q       <= s_we_d;
      s_addr_q     <= s_addr_d;
      s_wdata_q    <= s_wdata_d;
      s_be_q       <= s_be_d;
      busy_q       <= busy_d;
    end
  end

  assign M_ACK    = m_ack_q;
  assign M_RDATA  = m_rdata_q;
  assign S_EN     = s_en_q;
  assign S_WE     = s_we_q;
  assign S_ADDR   = s_addr_q;
  assign S_WDATA  = s_wdata_q;
  assign S_BE     = s_be_q;
  assign GRANT_ID = grant_id_q;
  assign BUSY     = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter. Two instances share one set of master inputs:
// u_a is round-robin, MEM_LAT=1, LOCK_TMO=4; u_b is fixed priority, MEM_LAT=3.
// Cycle n is observed 1 ns after the n-th clock edge following stimulus setup.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  m_req, m_we, m_lock;
  logic [38:0] m_addr;
  logic [95:0] m_wdata;
  logic [11:0] m_be;
  logic [31:0] s_rdata;

  logic [2:0]  a_ack, b_ack;
  logic [31:0] a_rdata, b_rdata;
  logic        a_s_en, b_s_en, a_s_we, b_s_we;
  logic [12:0] a_s_addr, b_s_addr;
  logic [31:0] a_s_wdata, b_s_wdata;
  logic [3:0]  a_s_be, b_s_be;
  logic [1:0]  a_grant, b_grant;
  logic        a_busy, b_busy;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.N_MASTERS(3), .ADDR_W(13), .DATA_W(32), .MEM_LAT(1),
                .PRIO_MODE(0), .LOCK_TMO(4)) u_a (
    .CLK(clk), .RESET(rst), .M_REQ(m_req), .M_WE(m_we), .M_LOCK(m_lock),
    .M_ADDR(m_addr), .M_WDATA(m_wdata), .M_BE(m_be), .M_ACK(a_ack),
    .M_RDATA(a_rdata), .S_EN(a_s_en), .S_WE(a_s_we), .S_ADDR(a_s_addr),
    .S_WDATA(a_s_wdata), .S_BE(a_s_be), .S_RDATA(s_rdata),
    .GRANT_ID(a_grant), .BUSY(a_busy));

  mem_arbiter #(.N_MASTERS(3), .ADDR_W(13), .DATA_W(32), .MEM_LAT(3),
                .PRIO_MODE(1), .LOCK_TMO(16)) u_b (
    .CLK(clk), .RESET(rst), .M_REQ(m_req), .M_WE(m_we), .M_LOCK(m_lock),
    .M_ADDR(m_addr), .M_WDATA(m_wdata), .M_BE(m_be), .M_ACK(b_ack),
    .M_RDATA(b_rdata), .S_EN(b_s_en), .S_WE(b_s_we), .S_ADDR(b_s_addr),
    .S_WDATA(b_s_wdata), .S_BE(b_s_be), .S_RDATA(s_rdata),
    .GRANT_ID(b_grant), .BUSY(b_busy));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_master(input int i, input logic we, input logic lock,
                            input logic [12:0] addr, input logic [31:0] wd,
                            input logic [3:0] be);
    m_we[i]            = we;
    m_lock[i]          = lock;
    m_addr[i*13 +: 13] = addr;
    m_wdata[i*32 +: 32] = wd;
    m_be[i*4 +: 4]     = be;
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    m_req = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    tests++;
    if ({a_ack, a_rdata, a_s_en, a_s_we, a_s_addr, a_s_wdata, a_s_be, a_grant, a_busy} !== '0) begin
      fails++;
      $display("FAIL reset_a got %h exp 0", {a_ack, a_rdata, a_s_en, a_s_we, a_s_addr, a_s_wdata, a_s_be, a_grant, a_busy});
    end
    tests++;
    if ({b_ack, b_rdata, b_s_en, b_s_we, b_s_addr, b_s_wdata, b_s_be, b_grant, b_busy} !== '0) begin
      fails++;
      $display("FAIL reset_b got %h exp 0", {b_ack, b_rdata, b_s_en, b_s_we, b_s_addr, b_s_wdata, b_s_be, b_grant, b_busy});
    end
    rst = 1'b0;
  endtask

  task automatic test_single_read();
    do_reset();
    s_rdata = 32'hDEADBEEF;
    set_master(1, 1'b0, 1'b0, 13'h0010, 32'h0, 4'hF);
    m_req = 3'b010;
    tick();
    tests++;
    if ({a_s_en, a_s_addr, a_grant, a_busy} !== {1'b1, 13'h0010, 2'd1, 1'b1}) begin
      fails++;
      $display("FAIL read_issue got en=%b addr=%h gid=%0d busy=%b exp en=1 addr=0010 gid=1 busy=1", a_s_en, a_s_addr, a_grant, a_busy);
    end
    tick();
    tests++;
    if ({a_ack, a_s_en} !== 4'b0000) begin
      fails++;
      $display("FAIL read_wait got ack=%b en=%b exp ack=000 en=0", a_ack, a_s_en);
    end
    tick();
    tests++;
    if (a_ack !== 3'b010 || a_rdata !== 32'hDEADBEEF) begin
      fails++;
      $display("FAIL read_ack got ack=%b rdata=%h exp ack=010 rdata=deadbeef", a_ack, a_rdata);
    end
    m_req = 3'b000;
    tick();
    tests++;
    if ({a_ack, a_busy} !== 4'b0000) begin
      fails++;
      $display("FAIL read_done got ack=%b busy=%b exp ack=000 busy=0", a_ack, a_busy);
    end
  endtask

  // Follows test_single_read without reset so M_RDATA still holds deadbeef.
  task automatic test_write();
    s_rdata = 32'h12345678;
    set_master(0, 1'b1, 1'b0, 13'h1ABC, 32'hCAFE0001, 4'b0101);
    m_req = 3'b001;
    tick();
    tests++;
    if ({a_s_en, a_s_we, a_s_addr, a_s_wdata, a_s_be, a_grant} !==
        {1'b1, 1'b1, 13'h1ABC, 32'hCAFE0001, 4'b0101, 2'd0}) begin
      fails++;
      $display("FAIL write_issue got en=%b we=%b addr=%h wd=%h be=%b gid=%0d exp 1 1 1abc cafe0001 0101 0", a_s_en, a_s_we, a_s_addr, a_s_wdata, a_s_be, a_grant);
    end
    tick();
    tick();
    tests++;
    if (a_ack !== 3'b001 || a_rdata !== 32'hDEADBEEF) begin
      fails++;
      $display("FAIL write_ack got ack=%b rdata=%h exp ack=001 rdata=deadbeef", a_ack, a_rdata);
    end
    m_req = 3'b000;
    tick();
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int i = 0; i < 3; i++) set_master(i, 1'b0, 1'b0, 13'(i + 5), 32'h0, 4'hF);
    m_req = 3'b111;
    for (int c = 1; c <= 24; c++) begin
      int j;
      tick();
      j = (c - 1) / 4;
      if ((c - 1) % 4 == 0) begin
        tests++;
        if ({a_s_en, a_grant} !== {1'b1, 2'(j % 3)}) begin
          fails++;
          $display("FAIL rr_grant c=%0d got en=%b gid=%0d exp en=1 gid=%0d", c, a_s_en, a_grant, j % 3);
        end
      end
      if ((c - 1) % 4 == 2) begin
        tests++;
        if (a_ack !== (3'b001 << (j % 3))) begin
          fails++;
          $display("FAIL rr_ack c=%0d got %b exp %b", c, a_ack, 3'b001 << (j % 3));
        end
      end
    end
    m_req = 3'b000;
    tick();
  endtask

  task automatic test_fixed_priority();
    int seen2;
    seen2 = 0;
    do_reset();
    s_rdata = 32'h0F0F0F0F;
    set_master(0, 1'b0, 1'b0, 13'h0100, 32'h0, 4'hF);
    set_master(2, 1'b0, 1'b0, 13'h0200, 32'h0, 4'hF);
    m_req = 3'b101;
    for (int c = 1; c <= 24; c++) begin
      tick();
      if (b_ack[2]) seen2++;
      if ((c - 1) % 6 == 0) begin
        tests++;
        if ({b_s_en, b_grant, b_s_addr} !== {1'b1, 2'd0, 13'h0100}) begin
          fails++;
          $display("FAIL prio_grant c=%0d got en=%b gid=%0d addr=%h exp en=1 gid=0 addr=0100", c, b_s_en, b_grant, b_s_addr);
        end
      end
      if ((c - 1) % 6 == 4) begin
        tests++;
        if (b_ack !== 3'b001 || b_rdata !== 32'h0F0F0F0F) begin
          fails++;
          $display("FAIL prio_ack c=%0d got ack=%b rdata=%h exp ack=001 rdata=0f0f0f0f", c, b_ack, b_rdata);
        end
      end
    end
    tests++;
    if (seen2 !== 0) begin
      fails++;
      $display("FAIL prio_starve got %0d acks to master 2 exp 0", seen2);
    end
    m_req = 3'b000;
    tick();
  endtask

  task automatic test_lock_hold();
    do_reset();
    set_master(2, 1'b0, 1'b1, 13'h0020, 32'h0, 4'hF);
    set_master(0, 1'b0, 1'b0, 13'h0030, 32'h0, 4'hF);
    m_req = 3'b100;
    tick();                                   // c1
    tests++;
    if ({a_s_en, a_grant} !== {1'b1, 2'd2}) begin
      fails++;
      $display("FAIL lock_first got en=%b gid=%0d exp en=1 gid=2", a_s_en, a_grant);
    end
    m_req = 3'b101;
    tick();                                   // c2
    tick();                                   // c3
    tests++;
    if (a_ack !== 3'b100) begin
      fails++;
      $display("FAIL lock_ack1 got %b exp 100", a_ack);
    end
    m_req[2]  = 1'b0;
    m_lock[2] = 1'b0;
    tick();                                   // c4
    tick();                                   // c5
    tests++;
    if ({a_busy, a_s_en} !== 2'b00) begin
      fails++;
      $display("FAIL lock_block5 got busy=%b en=%b exp 0 0", a_busy, a_s_en);
    end
    tick();                                   // c6
    tests++;
    if ({a_busy, a_s_en} !== 2'b00) begin
      fails++;
      $display("FAIL lock_block6 got busy=%b en=%b exp 0 0", a_busy, a_s_en);
    end
    m_req[2] = 1'b1;
    tick();                                   // c7
    tests++;
    if ({a_s_en, a_grant} !== {1'b1, 2'd2}) begin
      fails++;
      $display("FAIL lock_regrant got en=%b gid=%0d exp en=1 gid=2", a_s_en, a_grant);
    end
    tick();                                   // c8
    tick();                                   // c9
    tests++;
    if (a_ack !== 3'b100) begin
      fails++;
      $display("FAIL lock_ack2 got %b exp 100", a_ack);
    end
    m_req[2] = 1'b0;
    tick();                                   // c10
    tick();                                   // c11
    tests++;
    if ({a_s_en, a_grant, a_s_addr} !== {1'b1, 2'd0, 13'h0030}) begin
      fails++;
      $display("FAIL lock_release got en=%b gid=%0d addr=%h exp en=1 gid=0 addr=0030", a_s_en, a_grant, a_s_addr);
    end
    tick();                                   // c12
    tick();                                   // c13
    tests++;
    if (a_ack !== 3'b001) begin
      fails++;
      $display("FAIL lock_ack3 got %b exp 001", a_ack);
    end
    m_req = 3'b000;
    tick();
  endtask

  task automatic test_lock_timeout();
    do_reset();
    set_master(1, 1'b0, 1'b1, 13'h0044, 32'h0, 4'hF);
    set_master(0, 1'b0, 1'b0, 13'h0055, 32'h0, 4'hF);
    m_req = 3'b010;
    tick();                                   // c1
    tests++;
    if ({a_s_en, a_grant} !== {1'b1, 2'd1}) begin
      fails++;
      $display("FAIL tmo_first got en=%b gid=%0d exp en=1 gid=1", a_s_en, a_grant);
    end
    m_req = 3'b011;
    tick();                                   // c2
    tick();                                   // c3
    tests++;
    if (a_ack !== 3'b010) begin
      fails++;
      $display("FAIL tmo_ack got %b exp 010", a_ack);
    end
    m_req[1]  = 1'b0;
    m_lock[1] = 1'b0;
    for (int c = 4; c <= 8; c++) begin
      tick();
      tests++;
      if ({a_busy, a_s_en} !== 2'b00) begin
        fails++;
        $display("FAIL tmo_hold c=%0d got busy=%b en=%b exp 0 0", c, a_busy, a_s_en);
      end
    end
    tick();                                   // c9
    tests++;
    if ({a_s_en, a_grant, a_s_addr} !== {1'b1, 2'd0, 13'h0055}) begin
      fails++;
      $display("FAIL tmo_grant got en=%b gid=%0d addr=%h exp en=1 gid=0 addr=0055", a_s_en, a_grant, a_s_addr);
    end
    m_req = 3'b000;
    tick();
    tick();
    tick();
  endtask

  task automatic test_reset_mid_wait();
    do_reset();
    s_rdata = 32'h13579BDF;
    set_master(0, 1'b0, 1'b0, 13'h0A5A, 32'hA5A5A5A5, 4'hF);
    m_req = 3'b001;
    tick();                                   // c1
    tick();                                   // c2
    tick();                                   // c3: u_b in WAIT
    tests++;
    if ({b_busy, b_ack} !== 4'b1000) begin
      fails++;
      $display("FAIL midwait_pre got busy=%b ack=%b exp busy=1 ack=000", b_busy, b_ack);
    end
    rst   = 1'b1;
    m_req = 3'b000;
    tick();                                   // c4
    tests++;
    if ({b_ack, b_rdata, b_s_en, b_s_we, b_s_addr, b_s_wdata, b_s_be, b_grant, b_busy} !== '0) begin
      fails++;
      $display("FAIL midwait_b_zero got %h exp 0", {b_ack, b_rdata, b_s_en, b_s_we, b_s_addr, b_s_wdata, b_s_be, b_grant, b_busy});
    end
    tests++;
    if ({a_ack, a_rdata, a_s_en, a_s_we, a_s_addr, a_s_wdata, a_s_be, a_grant, a_busy} !== '0) begin
      fails++;
      $display("FAIL midwait_a_zero got %h exp 0", {a_ack, a_rdata, a_s_en, a_s_we, a_s_addr, a_s_wdata, a_s_be, a_grant, a_busy});
    end
    rst = 1'b0;
    set_master(1, 1'b0, 1'b0, 13'h0111, 32'h0, 4'hF);
    m_req = 3'b011;
    for (int c = 5; c <= 8; c++) begin
      tick();
      if (c == 5) begin
        tests++;
        if ({a_s_en, a_grant} !== {1'b1, 2'd0}) begin
          fails++;
          $display("FAIL midwait_first got en=%b gid=%0d exp en=1 gid=0", a_s_en, a_grant);
        end
      end
      tests++;
      if (b_ack !== 3'b000) begin
        fails++;
        $display("FAIL midwait_noack c=%0d got %b exp 000", c, b_ack);
      end
    end
    tick();                                   // c9
    tests++;
    if (b_ack !== 3'b001) begin
      fails++;
      $display("FAIL midwait_newack got %b exp 001", b_ack);
    end
    m_req = 3'b000;
    tick();
  endtask

  initial begin
    rst     = 1'b1;
    m_req   = '0;
    m_we    = '0;
    m_lock  = '0;
    m_addr  = '0;
    m_wdata = '0;
    m_be    = '0;
    s_rdata = '0;
    test_reset();
    test_single_read();
    test_write();
    test_round_robin();
    test_fixed_priority();
    test_lock_hold();
    test_lock_timeout();
    test_reset_mid_wait();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
